obstacle_spawner: RTL and testbench

Generates and moves the single on-screen obstacle for the dino game. It sits directly upstream of the engine's collision logic and the sprite loader, and drives `obsX`/`obsY` in place of hard-coded obstacle motion. Spawn gaps and obstacle type come from a 16-bit LFSR. Scroll speed ramps with the number of obstacles cleared.

---
 rtl/game_pkg.sv | 21 ++
 rtl/obstacle_spawner_if.sv | 31 +++
 rtl/lfsr16.sv | 22 ++
 rtl/obstacle_spawner.sv | 155 +++++++++++++++
 tb/tb_obstacle_spawner.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the dino game engine, the sprite loader
// and the obstacle spawner.
//   spawn_state_t : spawner FSM states
//   SCREEN_W      : visible screen width in px; obstacles spawn at its right edge
//   GROUND_Y_PX   : ground line y; obstacle bottoms sit on it
//   coord_t       : 12-bit screen coordinate
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GAP    = 2'd1,
        S_MOVE   = 2'd2,
        S_FROZEN = 2'd3
    } spawn_state_t;

    localparam int SCREEN_W    = 640;
    localparam int GROUND_Y_PX = 400;

    typedef logic [11:0] coord_t;

endpackage

// File: rtl/obstacle_spawner_if.sv
// obstacle_spawner_if: game-step controls into the spawner and obstacle
// state out of it.
//   tick, run          : game-step strobe and playing flag (master -> slave)
//   obsX, obsY         : obstacle left / top edge
//   obs_active         : obstacle visible and collidable
//   obs_tall           : 1 = tall cactus
//   spawn              : one-cycle pulse when a new obstacle appears
//   speed              : current scroll speed in px per tick
interface obstacle_spawner_if;
    import game_pkg::*;

    logic       tick;
    logic       run;
    coord_t     obsX;
    coord_t     obsY;
    logic       obs_active;
    logic       obs_tall;
    logic       spawn;
    logic [3:0] speed;

    modport master (
        output tick, run,
        input  obsX, obsY, obs_active, obs_tall, spawn, speed
    );

    modport slave (
        input  tick, run,
        output obsX, obsY, obs_active, obs_tall, spawn, speed
    );

endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   adv        : advance one step this cycle
//   state      : current 16-bit value
// SEED must be nonzero or the register locks up at zero.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else if (adv)
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end

endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: spawns and scrolls the single on-screen cactus.
//   clk25MHz : sole clock
//   resetKey : async active-low reset
//   bus      : obstacle_spawner_if slave (tick/run in, obstacle state out)
// Gap length and cactus type come from an LFSR sampled before that tick's
// advance. Every 8 clears bump the scroll speed, saturating at MAX_SPEED.
// A run drop while playing freezes everything (game-over frame) until reset.
module obstacle_spawner
    import game_pkg::*;
#(
    parameter int          SPAWN_X     = SCREEN_W,
    parameter int          GROUND_Y    = GROUND_Y_PX,
    parameter int          SMALL_H     = 30,
    parameter int          TALL_H      = 50,
    parameter int          MIN_GAP     = 8,
    parameter int          START_SPEED = 4,
    parameter int          MAX_SPEED   = 12,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic               clk25MHz,
    input logic               resetKey,
    obstacle_spawner_if.slave bus
);

    localparam coord_t X_SPAWN = coord_t'(SPAWN_X);
    localparam coord_t Y_SMALL = coord_t'(GROUND_Y - SMALL_H);
    localparam coord_t Y_TALL  = coord_t'(GROUND_Y - TALL_H);

    spawn_state_t state_q, state_d;
    logic [4:0]   gap_q, gap_d;
    coord_t       x_q, x_d, y_q, y_d;
    logic         act_q, act_d, tall_q, tall_d, spawn_q, spawn_d;
    logic [3:0]   speed_q, speed_d;
    logic [2:0]   cleared_q, cleared_d;

    logic [15:0]  lfsr;
    logic         lfsr_adv;
    logic         lfsr_unused;
    logic         playing;
    logic         clear_hit;
    logic [4:0]   gap_load;

    // GAP/MOVE advance only while run holds; IDLE steps on every tick.
    assign playing   = (state_q == S_GAP || state_q == S_MOVE) && bus.run;
    assign lfsr_adv  = bus.tick && (state_q == S_IDLE || playing);
    // Comparing before subtracting keeps obsX from ever wrapping below zero.
    assign clear_hit = x_q <= coord_t'(speed_q);
    assign gap_load  = 5'(MIN_GAP) + {1'b0, lfsr[3:0]};
    assign lfsr_unused = ^lfsr[15:5];

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk25MHz),
        .rst_n (resetKey),
        .adv   (lfsr_adv),
        .state (lfsr)
    );

    always_ff @(posedge clk25MHz or negedge resetKey) begin
        if (!resetKey)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.run) state_d = S_GAP;
            S_GAP: begin
                if (!bus.run)                        state_d = S_FROZEN;
                else if (bus.tick && gap_q == 5'd1)  state_d = S_MOVE;
            end
            S_MOVE: begin
                if (!bus.run)                        state_d = S_FROZEN;
                else if (bus.tick && clear_hit)      state_d = S_GAP;
            end
            S_FROZEN: state_d = S_FROZEN;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gap_d     = gap_q;
        x_d       = x_q;
        y_d       = y_q;
        act_d     = act_q;
        tall_d    = tall_q;
        spawn_d   = 1'b0;
        speed_d   = speed_q;
        cleared_d = cleared_q;
        unique case (state_q)
            S_IDLE: begin
                // A tick arriving with run only loads the gap; counting starts next tick.
                if (bus.run) gap_d = gap_load;
            end
            S_GAP: begin
                if (playing && bus.tick) begin
                    gap_d = gap_q - 5'd1;
                    if (gap_q == 5'd1) begin
                        tall_d  = lfsr[4];
                        y_d     = lfsr[4] ? Y_TALL : Y_SMALL;
                        x_d     = X_SPAWN;
                        act_d   = 1'b1;
                        spawn_d = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (playing && bus.tick) begin
                    if (clear_hit) begin
                        act_d     = 1'b0;
                        x_d       = X_SPAWN;
                        cleared_d = cleared_q + 3'd1;
                        if (cleared_q == 3'd7 && speed_q < 4'(MAX_SPEED))
                            speed_d = speed_q + 4'd1;
                        gap_d     = gap_load;
                    end else begin
                        x_d = x_q - coord_t'(speed_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk25MHz or negedge resetKey) begin
        if (!resetKey) begin
            gap_q     <= '0;
            x_q       <= X_SPAWN;
            y_q       <= Y_SMALL;
            act_q     <= 1'b0;
            tall_q    <= 1'b0;
            spawn_q   <= 1'b0;
            speed_q   <= 4'(START_SPEED);
            cleared_q <= '0;
        end else begin
            gap_q     <= gap_d;
            x_q       <= x_d;
            y_q       <= y_d;
            act_q     <= act_d;
            tall_q    <= tall_d;
            spawn_q   <= spawn_d;
            speed_q   <= speed_d;
            cleared_q <= cleared_d;
        end
    end

    assign bus.obsX       = x_q;
    assign bus.obsY       = y_q;
    assign bus.obs_active = act_q;
    assign bus.obs_tall   = tall_q;
    assign bus.spawn      = spawn_q;
    assign bus.speed      = speed_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed test of obstacle_spawner against a
// behavioural game model, checked every cycle, plus hand-computed literals.
module tb_obstacle_spawner;
    import game_pkg::*;

    logic clk25MHz = 1'b0;
    logic resetKey = 1'b0;
    obstacle_spawner_if bus ();

    obstacle_spawner dut (.clk25MHz(clk25MHz), .resetKey(resetKey), .bus(bus));

    always #20 clk25MHz = ~clk25MHz;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_GAP = 1, PH_MOVE = 2, PH_FROZEN = 3;
    int          m_ph, m_gap, m_x, m_y, m_speed, m_cleared, m_nclr;
    bit          m_act, m_tall, m_spawn;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk25MHz or negedge resetKey) begin
        if (!resetKey) begin
            m_ph = PH_IDLE; m_gap = 0; m_x = 640; m_y = 370; m_speed = 4;
            m_cleared = 0; m_nclr = 0; m_act = 0; m_tall = 0; m_spawn = 0;
            m_lfsr = 16'hACE1;
        end else begin
            logic [15:0] pre;
            pre = m_lfsr;
            m_spawn = 0;
            if (m_ph == PH_FROZEN) begin
                // everything held
            end else if (m_ph != PH_IDLE && !bus.run) begin
                m_ph = PH_FROZEN;
            end else begin
                if (m_ph == PH_IDLE) begin
                    if (bus.run) begin m_gap = 8 + int'(pre[3:0]); m_ph = PH_GAP; end
                end else if (m_ph == PH_GAP) begin
                    if (bus.tick) begin
                        m_gap = m_gap - 1;
                        if (m_gap == 0) begin
                            m_tall = pre[4]; m_y = 400 - (m_tall ? 50 : 30);
                            m_x = 640; m_act = 1; m_spawn = 1; m_ph = PH_MOVE;
                        end
                    end
                end else begin
                    if (bus.tick) begin
                        if (m_x <= m_speed) begin
                            m_act = 0; m_x = 640; m_nclr = m_nclr + 1;
                            m_cleared = (m_cleared + 1) % 8;
                            if (m_cleared == 0 && m_speed < 12) m_speed = m_speed + 1;
                            m_gap = 8 + int'(pre[3:0]); m_ph = PH_GAP;
                        end else begin
                            m_x = m_x - m_speed;
                        end
                    end
                end
                if (bus.tick) m_lfsr = lfsr_next(m_lfsr);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("obsX", int'(bus.obsX), m_x);
        chk("obsY", int'(bus.obsY), m_y);
        chk("obs_active", int'(bus.obs_active), int'(m_act));
        chk("obs_tall", int'(bus.obs_tall), int'(m_tall));
        chk("spawn", int'(bus.spawn), int'(m_spawn));
        chk("speed", int'(bus.speed), m_speed);
    endtask

    // One clock with the given tick level; outputs are checked 2 units after the edge.
    task automatic step(input bit t);
        bus.tick = t;
        @(posedge clk25MHz);
        #2;
        bus.tick = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        bus.run  = 1'b0;
        bus.tick = 1'b0;
        resetKey = 1'b0;
        repeat (2) @(posedge clk25MHz);
        #2;
        chk("rst_obsX", int'(bus.obsX), 640);
        chk("rst_obsY", int'(bus.obsY), 370);
        chk("rst_active", int'(bus.obs_active), 0);
        chk("rst_speed", int'(bus.speed), 4);
        chk("rst_spawn", int'(bus.spawn), 0);
        compare_all();
        resetKey = 1'b1;
    endtask

    // run, then 9 ticks separated by idle cycles; seed gap is 9, type small.
    task automatic first_spawn();
        bus.run = 1'b1;
        step(1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b1);
            if (i == 4) chk("lfsr_after4", int'(dut.u_lfsr.state), int'(16'hCE1E));
            if (i < 9) begin
                chk("no_early_spawn", int'(bus.spawn), 0);
                step(1'b0);
            end
        end
        chk("fs_spawn", int'(bus.spawn), 1);
        chk("fs_active", int'(bus.obs_active), 1);
        chk("fs_obsX", int'(bus.obsX), 640);
        chk("fs_tall", int'(bus.obs_tall), 0);
        chk("fs_obsY", int'(bus.obsY), 370);
        step(1'b0);
        chk("fs_spawn_drop", int'(bus.spawn), 0);
    endtask

    task automatic clears_to(input int n);
        int budget = 20000;
        while (m_nclr < n && budget > 0) begin
            step(1'b1);
            budget--;
        end
        chk("clear_budget", m_nclr, n);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        logic [15:0] saved;
        bus.tick = 1'b0;
        bus.run  = 1'b0;
        #1;
        do_reset();

        first_spawn();

        // motion and clear at speed 4
        step(1'b1);
        chk("move_first", int'(bus.obsX), 636);
        repeat (158) step(1'b1);
        chk("move_159", int'(bus.obsX), 4);
        chk("move_159_active", int'(bus.obs_active), 1);
        step(1'b1);
        chk("clear_active", int'(bus.obs_active), 0);
        chk("clear_obsX", int'(bus.obsX), 640);
        chk("clear_state", int'(dut.state_q), int'(S_GAP));

        // freeze at obsX = 300 with a same-cycle tick
        budget = 2000;
        while (!(m_act && m_x == 300) && budget > 0) begin step(1'b1); budget--; end
        chk("reach_300", int'(bus.obsX), 300);
        saved = m_lfsr;
        bus.run = 1'b0;
        step(1'b1);
        repeat (20) step(1'b1);
        chk("frz_obsX", int'(bus.obsX), 300);
        chk("frz_active", int'(bus.obs_active), 1);
        chk("frz_spawn", int'(bus.spawn), 0);
        chk("frz_state", int'(dut.state_q), int'(S_FROZEN));
        chk("frz_lfsr", int'(dut.u_lfsr.state), int'(saved));
        do_reset();

        // reset mid-GAP with gap_cnt = 5, then first spawn must repeat exactly
        bus.run = 1'b1;
        step(1'b0);
        budget = 50;
        while (m_gap != 5 && budget > 0) begin step(1'b1); budget--; end
        chk("midgap_state", int'(dut.state_q), int'(S_GAP));
        chk("midgap_gap", int'(dut.gap_q), 5);
        do_reset();
        chk("reseed", int'(dut.u_lfsr.state), int'(16'hACE1));
        first_spawn();

        // speed ramp: 4 -> 5 after 8 clears, saturate at 12 after 64
        clears_to(8);
        chk("speed_8", int'(bus.speed), 5);
        clears_to(64);
        chk("speed_64", int'(bus.speed), 12);
        clears_to(72);
        chk("speed_72", int'(bus.speed), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
